blob_rom_arbiter: RTL and testbench

Shares one synchronous sprite/picture ROM between NUM_REQ picture-blob renderers, so several sprites can be drawn without duplicating image ROMs.
- Grants one ROM read per clock using round-robin priority.
- Registers the ROM address and tracks each outstanding read with a requester tag.
- Returns each read word to the requester that issued it, in issue order.
- Sits between the blob renderers and the image ROM; the colour maps follow the ROM data path unchanged.

---
 rtl/blob_rom_arbiter.sv | 146 ++++++++++++++
 tb/tb_blob_rom_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/blob_rom_arbiter.sv
// blob_rom_arbiter: lets NUM_REQ picture-blob renderers share one synchronous
// image ROM. A round-robin arbiter grants one read per clock and registers the
// ROM address. A tag pipeline that runs alongside the ROM latency routes each
// returned word back to the requester that issued it, in issue order.
module blob_rom_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 8,
  parameter int ROM_LAT = 1
) (
  input  logic                        pixel_clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic                        hold,
  output logic [NUM_REQ-1:0]          gnt,
  output logic [ADDR_W-1:0]           rom_addr,
  output logic                        rom_rd,
  input  logic [DATA_W-1:0]           rom_data,
  output logic [NUM_REQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]           rsp_data,
  output logic                        busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [IDX_W:0]   NUM_REQ_W = (IDX_W+1)'(NUM_REQ);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);

  // Round-robin pointer: the requester that gets first look next cycle.
  logic [IDX_W-1:0] ptr_reg;

  // Unpacked view of the per-requester addresses.
  logic [ADDR_W-1:0] addr_arr [NUM_REQ];

  // rot_idx[k] = (ptr + k) mod NUM_REQ, the k-th candidate in search order.
  logic [IDX_W-1:0] rot_idx [NUM_REQ];

  // Winner of the search, before gating by reset/hold.
  logic             sel_found;
  logic [IDX_W-1:0] sel_idx;
  logic             grant_en;
  logic             accept;
  logic [IDX_W-1:0] ptr_next;

  // Tag pipeline. Stage 0 is loaded on the edge that registers rom_addr, and
  // stage ROM_LAT lines up with the cycle in which rom_data is valid.
  logic [ROM_LAT:0] tag_valid_reg;
  logic [IDX_W-1:0] tag_idx_reg [ROM_LAT+1];

  logic [NUM_REQ-1:0] rsp_valid_next;

  genvar gi;

  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      logic [IDX_W:0] rot_sum;

      assign addr_arr[gi] = req_addr[gi*ADDR_W +: ADDR_W];

      // Modulo by a single conditional subtract: ptr + gi < 2*NUM_REQ.
      assign rot_sum      = {1'b0, ptr_reg} + (IDX_W+1)'(gi);
      assign rot_idx[gi]  = (rot_sum >= NUM_REQ_W) ? IDX_W'(rot_sum - NUM_REQ_W)
                                                   : IDX_W'(rot_sum);

      // One-hot grant, combinational so the requester sees it in the same cycle.
      assign gnt[gi] = accept && (sel_idx == IDX_W'(gi));

      // Response strobe decoded from the tag that is leaving the pipeline.
      assign rsp_valid_next[gi] = tag_valid_reg[ROM_LAT] &&
                                  (tag_idx_reg[ROM_LAT] == IDX_W'(gi));
    end
  endgenerate

  // Search upward from ptr with wrap-around for the first active request.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!sel_found && req[rot_idx[k]]) begin
        sel_found = 1'b1;
        sel_idx   = rot_idx[k];
      end
    end
  end

  // Reset and hold both suppress grants immediately, before the next edge.
  assign grant_en = !reset && !hold;
  assign accept   = grant_en && sel_found;
  assign ptr_next = (sel_idx == LAST_IDX) ? '0 : sel_idx + IDX_W'(1);

  // Issue stage: register the granted address and advance the pointer.
  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      ptr_reg  <= '0;
      rom_rd   <= 1'b0;
      rom_addr <= '0;
    end else begin
      rom_rd <= accept;
      if (accept) begin
        rom_addr <= addr_arr[sel_idx];
        ptr_reg  <= ptr_next;
      end
    end
  end

  // Tag stage 0: captured together with rom_addr.
  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      tag_valid_reg[0] <= 1'b0;
    end else begin
      tag_valid_reg[0] <= accept;
    end
    tag_idx_reg[0] <= sel_idx;
  end

  generate
    for (gi = 1; gi <= ROM_LAT; gi++) begin : g_tag
      // Tag stage gi: follows the read through the ROM latency.
      always_ff @(posedge pixel_clk) begin
        if (reset) begin
          tag_valid_reg[gi] <= 1'b0;
        end else begin
          tag_valid_reg[gi] <= tag_valid_reg[gi-1];
        end
        tag_idx_reg[gi] <= tag_idx_reg[gi-1];
      end
    end
  endgenerate

  // Response stage: capture ROM data only for a live tag so rsp_data holds otherwise.
  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      rsp_valid <= '0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= rsp_valid_next;
      if (tag_valid_reg[ROM_LAT]) begin
        rsp_data <= rom_data;
      end
    end
  end

  // Any live tag means an accepted read still owes its response.
  assign busy = |tag_valid_reg;

endmodule

// File: tb/tb_blob_rom_arbiter.sv
// Directed bench for blob_rom_arbiter: one instance with ROM_LAT=1, one with
// ROM_LAT=3, each fed by a ROM model returning addr[7:0] ^ 8'hA5.
module tb_blob_rom_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  // ---------------- instance A: ROM_LAT = 1 ----------------
  logic        reset;
  logic [3:0]  req;
  logic [47:0] req_addr;
  logic        hold;
  logic [3:0]  gnt;
  logic [11:0] rom_addr;
  logic        rom_rd;
  logic [7:0]  rom_data;
  logic [3:0]  rsp_valid;
  logic [7:0]  rsp_data;
  logic        busy;

  blob_rom_arbiter #(.NUM_REQ(4), .ADDR_W(12), .DATA_W(8), .ROM_LAT(1)) u_dut (
    .pixel_clk(clk), .reset(reset), .req(req), .req_addr(req_addr), .hold(hold),
    .gnt(gnt), .rom_addr(rom_addr), .rom_rd(rom_rd), .rom_data(rom_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy)
  );

  always @(posedge clk) rom_data <= rom_addr[7:0] ^ 8'hA5;

  // ---------------- instance B: ROM_LAT = 3 ----------------
  logic        reset_b;
  logic [3:0]  req_b;
  logic [47:0] req_addr_b;
  logic        hold_b;
  logic [3:0]  gnt_b;
  logic [11:0] rom_addr_b;
  logic        rom_rd_b;
  logic [7:0]  rom_data_b;
  logic [3:0]  rsp_valid_b;
  logic [7:0]  rsp_data_b;
  logic        busy_b;
  logic [7:0]  rom_p0, rom_p1;

  blob_rom_arbiter #(.NUM_REQ(4), .ADDR_W(12), .DATA_W(8), .ROM_LAT(3)) u_dut_b (
    .pixel_clk(clk), .reset(reset_b), .req(req_b), .req_addr(req_addr_b), .hold(hold_b),
    .gnt(gnt_b), .rom_addr(rom_addr_b), .rom_rd(rom_rd_b), .rom_data(rom_data_b),
    .rsp_valid(rsp_valid_b), .rsp_data(rsp_data_b), .busy(busy_b)
  );

  always @(posedge clk) begin
    rom_p0     <= rom_addr_b[7:0] ^ 8'hA5;
    rom_p1     <= rom_p0;
    rom_data_b <= rom_p1;
  end

  // ---------------- helpers ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    if (obs === exp) $display("  check %s = %0h ok", tag, obs);
  endtask

  task automatic set_addr(input int i, input logic [11:0] a);
    req_addr[i*12 +: 12] = a;
  endtask

  task automatic set_addr_b(input int i, input logic [11:0] a);
    req_addr_b[i*12 +: 12] = a;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; req = '0; req_addr = '0; hold = 1'b0;
    reset_b = 1'b1; req_b = '0; req_addr_b = '0; hold_b = 1'b0;
    tick;
    tick;

    // ---- reset state ----
    req = 4'b1111;
    #1;
    chk("rst_gnt", gnt, 4'b0000);
    chk("rst_rom_rd", rom_rd, 1'b0);
    chk("rst_rom_addr", rom_addr, 12'h000);
    chk("rst_rsp_valid", rsp_valid, 4'b0000);
    chk("rst_rsp_data", rsp_data, 8'h00);
    chk("rst_busy", busy, 1'b0);
    req = '0;
    reset = 1'b0;

    // ---- 1: single read ----
    set_addr(2, 12'h012);
    req = 4'b0100;
    #1;
    chk("t1_gnt", gnt, 4'b0100);
    tick;
    req = '0;
    chk("t1_rom_addr", rom_addr, 12'h012);
    chk("t1_rom_rd", rom_rd, 1'b1);
    chk("t1_busy_issue", busy, 1'b1);
    tick;
    chk("t1_rom_rd_low", rom_rd, 1'b0);
    chk("t1_rsp_early", rsp_valid, 4'b0000);
    chk("t1_busy_mid", busy, 1'b1);
    tick;
    chk("t1_rsp_valid", rsp_valid, 4'b0100);
    chk("t1_rsp_data", rsp_data, 8'hB7);
    chk("t1_busy_done", busy, 1'b0);
    tick;
    chk("t1_rsp_single", rsp_valid, 4'b0000);
    chk("t1_rsp_hold", rsp_data, 8'hB7);

    // ---- 2: all requesters, one read each (ptr back to 0 via reset) ----
    reset = 1'b1;
    tick;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) set_addr(i, 12'h100 + 12'(i));
    req = 4'b1111;
    for (int c = 0; c < 6; c++) begin
      logic [3:0] exp_v;
      logic [7:0] exp_d;
      #1;
      if (c < 4) chk($sformatf("t2_gnt%0d", c), gnt, 4'b0001 << c);
      tick;
      if (c < 4) begin
        req[c] = 1'b0;
        chk($sformatf("t2_addr%0d", c), rom_addr, 12'h100 + 12'(c));
      end
      exp_v = (c >= 2) ? (4'b0001 << (c - 2)) : 4'b0000;
      chk($sformatf("t2_rsp_valid_c%0d", c), rsp_valid, exp_v);
      if (c >= 2) begin
        exp_d = 8'(c - 2) ^ 8'hA5;
        chk($sformatf("t2_rsp_data_c%0d", c), rsp_data, exp_d);
      end
    end
    tick;
    chk("t2_rsp_end", rsp_valid, 4'b0000);
    chk("t2_busy_end", busy, 1'b0);

    // ---- 3: fairness, req0 held, req3 pulsed ----
    set_addr(0, 12'h200);
    set_addr(3, 12'h203);
    req = 4'b0001;
    #1;
    chk("t3_gnt_a", gnt, 4'b0001);
    tick;
    chk("t3_addr_a", rom_addr, 12'h200);
    req = 4'b1001;
    #1;
    chk("t3_gnt_b", gnt, 4'b1000);
    tick;
    chk("t3_addr_b", rom_addr, 12'h203);
    #1;
    chk("t3_gnt_c", gnt, 4'b0001);
    tick;
    #1;
    chk("t3_gnt_d", gnt, 4'b1000);
    tick;
    req = 4'b0001;
    #1;
    chk("t3_gnt_e", gnt, 4'b0001);
    tick;
    req = '0;
    tick;
    tick;
    tick;
    chk("t3_busy_end", busy, 1'b0);

    // ---- 4: hold during continuous req = 0011 (ptr = 1) ----
    set_addr(0, 12'h300);
    set_addr(1, 12'h301);
    req = 4'b0011;
    #1;
    chk("t4_gnt0", gnt, 4'b0010);
    tick;
    #1;
    chk("t4_gnt1", gnt, 4'b0001);
    tick;
    hold = 1'b1;
    #1;
    chk("t4_hold_gnt2", gnt, 4'b0000);
    tick;
    chk("t4_hold_rd2", rom_rd, 1'b0);
    chk("t4_rsp_v2", rsp_valid, 4'b0010);
    chk("t4_rsp_d2", rsp_data, 8'hA4);
    chk("t4_busy2", busy, 1'b1);
    #1;
    chk("t4_hold_gnt3", gnt, 4'b0000);
    tick;
    chk("t4_hold_rd3", rom_rd, 1'b0);
    chk("t4_rsp_v3", rsp_valid, 4'b0001);
    chk("t4_rsp_d3", rsp_data, 8'hA5);
    chk("t4_busy3", busy, 1'b0);
    #1;
    chk("t4_hold_gnt4", gnt, 4'b0000);
    tick;
    chk("t4_hold_rd4", rom_rd, 1'b0);
    chk("t4_rsp_v4", rsp_valid, 4'b0000);
    hold = 1'b0;
    #1;
    chk("t4_resume_gnt", gnt, 4'b0010);
    tick;
    req = '0;
    chk("t4_resume_addr", rom_addr, 12'h301);
    chk("t4_resume_rd", rom_rd, 1'b1);
    tick;
    tick;
    tick;

    // ---- 5: reset mid-flight (ptr = 2) ----
    set_addr(1, 12'h051);
    set_addr(2, 12'h052);
    req = 4'b0110;
    #1;
    chk("t5_gnt_r2", gnt, 4'b0100);
    tick;
    req = 4'b0010;
    #1;
    chk("t5_gnt_r1", gnt, 4'b0010);
    tick;
    req = '0;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    chk("t5_busy", busy, 1'b0);
    chk("t5_rom_rd", rom_rd, 1'b0);
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("t5_no_rsp%0d", c), rsp_valid, 4'b0000);
      tick;
    end
    req = 4'b1111;
    #1;
    chk("t5_gnt_after_rst", gnt, 4'b0001);
    req = '0;

    // ---- 6: back-to-back single requester, ROM_LAT = 3 ----
    reset_b = 1'b0;
    req_b = 4'b0010;
    for (int c = 0; c < 12; c++) begin
      if (c < 8) set_addr_b(1, 12'(c));
      #1;
      chk($sformatf("t6_gnt_c%0d", c), gnt_b, (c < 8) ? 4'b0010 : 4'b0000);
      tick;
      if (c == 7) req_b = '0;
      chk($sformatf("t6_rsp_valid_c%0d", c), rsp_valid_b, (c >= 4) ? 4'b0010 : 4'b0000);
      if (c >= 4) chk($sformatf("t6_rsp_data_c%0d", c), rsp_data_b, 8'(c - 4) ^ 8'hA5);
      chk($sformatf("t6_busy_c%0d", c), busy_b, (c < 11) ? 1'b1 : 1'b0);
    end
    tick;
    chk("t6_rsp_end", rsp_valid_b, 4'b0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
